// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- instruction-fetch stage between the PC unit and the ID stage.
//
// Issues one fetch at a time to instruction memory, loads the returned word
// into the IF/ID pipeline register and tells the PC unit when to advance
// (o_pcwen). A one-entry skid buffer absorbs a response that arrives while
// ID is stalled with IF/ID full. Redirects (i_flush) squash IF/ID, drop any
// buffered word and mark an in-flight response as stale so it is discarded
// when it finally arrives.
//
// Optional build macro: IFU_PERF_EN adds saturating 32-bit counters of
// IF/ID loads (o_perf_fetch) and discarded responses/buffers (o_perf_drop).
//
// Ports:
//   i_clk, i_rst          core clock, synchronous active-high reset
//   i_pc                  current PC from the PC register
//   i_flush               redirect from the branch unit (same cycle)
//   i_stall               ID stage cannot accept, hold IF/ID
//   o_pcwen               PC register write enable (combinational)
//   o_imem_req_valid      fetch request valid (combinational)
//   i_imem_req_ready      imem accepts the request
//   o_imem_addr           fetch address (= i_pc)
//   i_imem_rsp_valid      single-cycle response strobe, no back-pressure
//   i_imem_rsp_data       fetched instruction
//   i_imem_rsp_err        access fault
//   o_ifid_valid/pc/inst/err   IF/ID pipeline register
// ---------------------------------------------------------------------------
module ifu_fetch #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_flush,
    input  logic              i_stall,
    output logic              o_pcwen,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_rsp_valid,
    input  logic [INST_W-1:0] i_imem_rsp_data,
    input  logic              i_imem_rsp_err,
    output logic              o_ifid_valid,
    output logic [ADDR_W-1:0] o_ifid_pc,
    output logic [INST_W-1:0] o_ifid_inst,
    output logic              o_ifid_err
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]       o_perf_fetch,
    output logic [31:0]       o_perf_drop
`endif
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   req_pc_q;
    logic [ADDR_W-1:0]   skid_pc_q;
    logic [INST_W-1:0]   skid_inst_q;
    logic                skid_err_q;
    logic                ifid_valid_q;
    logic [ADDR_W-1:0]   ifid_pc_q;
    logic [INST_W-1:0]   ifid_inst_q;
    logic                ifid_err_q;

    logic                req_valid_s;
    logic                hs_s;
    logic                accept_s;
    logic                pcwen_s;
    logic                load_s;
    logic [ADDR_W-1:0]   load_pc_s;
    logic [INST_W-1:0]   load_inst_s;
    logic                load_err_s;
    logic                skid_wr_s;
    logic                drop_s;

    // Request side: a flush retracts the request so the redirect target is fetched next.
    always_comb begin
        req_valid_s = (state_q == ST_REQ) & ~i_flush & ~i_rst;
        hs_s        = req_valid_s & i_imem_req_ready;
        // IF/ID can take a new entry unless ID is stalled on a valid instruction.
        accept_s    = ~(i_stall & ifid_valid_q);
    end

    // Next-state, PC write enable and IF/ID load source selection.
    always_comb begin
        state_d     = state_q;
        pcwen_s     = 1'b0;
        load_s      = 1'b0;
        load_pc_s   = req_pc_q;
        load_inst_s = i_imem_rsp_data;
        load_err_s  = i_imem_rsp_err;
        skid_wr_s   = 1'b0;
        drop_s      = 1'b0;
        if (i_rst) begin
            state_d = ST_REQ;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (i_flush) begin
                        pcwen_s = 1'b1;
                    end else if (hs_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (i_imem_rsp_valid) begin
                        if (i_flush) begin
                            pcwen_s = 1'b1;
                            drop_s  = 1'b1;
                            state_d = ST_REQ;
                        end else if (accept_s) begin
                            load_s  = 1'b1;
                            pcwen_s = 1'b1;
                            state_d = ST_REQ;
                        end else begin
                            skid_wr_s = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end else if (i_flush) begin
                        pcwen_s = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (i_flush) begin
                        pcwen_s = 1'b1;
                        drop_s  = 1'b1;
                        state_d = ST_REQ;
                    end else if (~i_stall) begin
                        load_s      = 1'b1;
                        load_pc_s   = skid_pc_q;
                        load_inst_s = skid_inst_q;
                        load_err_s  = skid_err_q;
                        pcwen_s     = 1'b1;
                        state_d     = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DROP: begin
                    // A stale response that coincides with another flush still ends
                    // the drop; waiting further would deadlock (no request is open).
                    if (i_imem_rsp_valid) begin
                        drop_s  = 1'b1;
                        pcwen_s = i_flush;
                        state_d = ST_REQ;
                    end else if (i_flush) begin
                        pcwen_s = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // State, request PC and skid buffer registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_REQ;
            req_pc_q    <= {ADDR_W{1'b0}};
            skid_pc_q   <= {ADDR_W{1'b0}};
            skid_inst_q <= NOP_INST;
            skid_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs_s) begin
                req_pc_q <= i_pc;
            end
            if (skid_wr_s) begin
                skid_pc_q   <= req_pc_q;
                skid_inst_q <= i_imem_rsp_data;
                skid_err_q  <= i_imem_rsp_err;
            end
        end
    end

    // IF/ID pipeline register: flush beats stall beats load; no load is a bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= {ADDR_W{1'b0}};
            ifid_inst_q  <= NOP_INST;
            ifid_err_q   <= 1'b0;
        end else if (i_flush) begin
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= NOP_INST;
            ifid_err_q   <= 1'b0;
        end else if (i_stall & ifid_valid_q) begin
            ifid_valid_q <= ifid_valid_q;
        end else if (load_s) begin
            ifid_valid_q <= 1'b1;
            ifid_pc_q    <= load_pc_s;
            ifid_inst_q  <= load_inst_s;
            ifid_err_q   <= load_err_s;
        end else begin
            ifid_valid_q <= 1'b0;
        end
    end

    assign o_pcwen          = pcwen_s;
    assign o_imem_req_valid = req_valid_s;
    assign o_imem_addr      = i_pc;
    assign o_ifid_valid     = ifid_valid_q;
    assign o_ifid_pc        = ifid_pc_q;
    assign o_ifid_inst      = ifid_inst_q;
    assign o_ifid_err       = ifid_err_q;

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_drop_q;

    // Saturating performance counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_fetch_q <= 32'd0;
            perf_drop_q  <= 32'd0;
        end else begin
            if (load_s & ~i_flush & accept_s & (perf_fetch_q != 32'hFFFFFFFF)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (drop_s & (perf_drop_q != 32'hFFFFFFFF)) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
        end
    end

    assign o_perf_fetch = perf_fetch_q;
    assign o_perf_drop  = perf_drop_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch -- randomized bench for ifu_fetch with a transaction-level
// reference model (outstanding-request flag, stale flag, one-slot buffer,
// IF/ID record). A small imem model answers each accepted request after a
// random latency; a PC model advances on the expected PC write enable.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

    localparam int          ADDR_W = 64;
    localparam int          INST_W = 32;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam int          NCYC   = 2000;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc;
    logic              flush, stall, ready, rsp_valid, rsp_err;
    logic [INST_W-1:0] rsp_data;
    logic              pcwen, req_valid, ifid_valid, ifid_err;
    logic [ADDR_W-1:0] addr, ifid_pc;
    logic [INST_W-1:0] ifid_inst;
`ifdef IFU_PERF_EN
    logic [31:0]       perf_fetch, perf_drop;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pc             (pc),
        .i_flush          (flush),
        .i_stall          (stall),
        .o_pcwen          (pcwen),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (ready),
        .o_imem_addr      (addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_imem_rsp_err   (rsp_err),
        .o_ifid_valid     (ifid_valid),
        .o_ifid_pc        (ifid_pc),
        .o_ifid_inst      (ifid_inst),
        .o_ifid_err       (ifid_err)
`ifdef IFU_PERF_EN
        ,
        .o_perf_fetch     (perf_fetch),
        .o_perf_drop      (perf_drop)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp_v);
        end
    endtask

    // Reference model state
    bit          m_out, m_stale, m_buf;
    logic [63:0] m_out_pc, m_buf_pc;
    logic [31:0] m_buf_inst;
    bit          m_buf_err;
    bit          m_v, m_err;
    logic [63:0] m_pc;
    logic [31:0] m_inst;
    longint      m_fetch, m_drop;

    // imem / PC unit models
    int          imem_cnt;
    logic [31:0] imem_data;
    bit          imem_err;
    logic [63:0] flush_tgt;

    initial begin
        bit          e_rv, e_pw, accept, hs, ldv;
        logic [63:0] n_pc;
        logic [31:0] n_inst;
        bit          n_err;

        rst = 1'b1; pc = 64'h80000000; flush = 1'b0; stall = 1'b0; ready = 1'b1;
        rsp_valid = 1'b0; rsp_data = 32'h0; rsp_err = 1'b0;
        imem_cnt = 0; imem_data = 32'h0; imem_err = 1'b0; flush_tgt = 64'h0;
        m_out = 0; m_stale = 0; m_buf = 0; m_out_pc = 64'h0; m_buf_pc = 64'h0;
        m_buf_inst = 32'h0; m_buf_err = 0; m_v = 0; m_err = 0; m_pc = 64'h0;
        m_inst = NOP; m_fetch = 0; m_drop = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Expected combinational outputs for the current inputs
            accept = !(stall && m_v);
            if (rst) begin
                e_rv = 0; e_pw = 0;
            end else begin
                e_rv = !m_out && !m_buf && !flush;
                e_pw = flush
                    || (rsp_valid && m_out && !m_stale && accept)
                    || (m_buf && accept);
            end
            hs = e_rv && ready;

            check_eq("req_valid",  {63'd0, req_valid},  {63'd0, e_rv});
            check_eq("pcwen",      {63'd0, pcwen},      {63'd0, e_pw});
            check_eq("imem_addr",  addr,                pc);
            check_eq("ifid_valid", {63'd0, ifid_valid}, {63'd0, m_v});
            check_eq("ifid_pc",    ifid_pc,             m_pc);
            check_eq("ifid_inst",  {32'd0, ifid_inst},  {32'd0, m_inst});
            check_eq("ifid_err",   {63'd0, ifid_err},   {63'd0, m_err});
`ifdef IFU_PERF_EN
            check_eq("perf_fetch", {32'd0, perf_fetch}, m_fetch);
            check_eq("perf_drop",  {32'd0, perf_drop},  m_drop);
`endif

            // Advance the model to the state after this clock edge
            if (rst) begin
                m_out = 0; m_stale = 0; m_buf = 0; m_v = 0; m_pc = 64'h0;
                m_inst = NOP; m_err = 0; m_fetch = 0; m_drop = 0;
            end else begin
                ldv = 0; n_pc = 64'h0; n_inst = 32'h0; n_err = 0;
                if (m_buf) begin
                    if (flush) begin
                        m_drop++; m_buf = 0;
                    end else if (accept) begin
                        ldv = 1; n_pc = m_buf_pc; n_inst = m_buf_inst; n_err = m_buf_err;
                        m_buf = 0;
                    end
                end
                if (rsp_valid && m_out) begin
                    if (m_stale || flush) begin
                        m_drop++;
                    end else if (accept) begin
                        ldv = 1; n_pc = m_out_pc; n_inst = rsp_data; n_err = rsp_err;
                    end else begin
                        m_buf = 1; m_buf_pc = m_out_pc; m_buf_inst = rsp_data; m_buf_err = rsp_err;
                    end
                    m_out = 0; m_stale = 0;
                end else if (flush && m_out) begin
                    m_stale = 1;
                end
                if (hs) begin
                    m_out = 1; m_stale = 0; m_out_pc = pc;
                end
                if (flush) begin
                    m_v = 0; m_inst = NOP; m_err = 0;
                end else if (stall && m_v) begin
                    m_v = m_v;
                end else if (ldv) begin
                    m_v = 1; m_pc = n_pc; m_inst = n_inst; m_err = n_err;
                    m_fetch++;
                end else begin
                    m_v = 0;
                end
            end

            @(posedge clk);
            #1;
            // PC unit and imem react to the edge that just happened
            if (rst) begin
                pc = 64'h80000000; imem_cnt = 0;
            end else begin
                if (e_pw) pc = flush ? flush_tgt : pc + 64'd4;
                if (hs) begin
                    imem_cnt  = (cyc < 10) ? 1 : $urandom_range(1, 3);
                    imem_data = (cyc < 6) ? 32'h00100093 : $urandom;
                    imem_err  = (cyc < 10) ? 1'b0 : ($urandom_range(0, 7) == 0);
                end
            end

            // New stimulus for the next cycle
            rst = (cyc + 1 < 3) || (cyc + 1 >= 1000 && cyc + 1 < 1003);
            rsp_valid = 1'b0; rsp_data = $urandom; rsp_err = $urandom_range(0, 1);
            if (!rst && imem_cnt > 0) begin
                imem_cnt--;
                if (imem_cnt == 0) begin
                    rsp_valid = 1'b1; rsp_data = imem_data; rsp_err = imem_err;
                end
            end
            if (rst) imem_cnt = 0;
            if (cyc + 1 < 10) begin
                ready = 1'b1; stall = 1'b0; flush = 1'b0;
            end else begin
                ready = ($urandom_range(0, 3) != 0);
                stall = ($urandom_range(0, 2) == 0);
                flush = ($urandom_range(0, 9) == 0);
                flush_tgt = 64'h80000000 + {52'd0, 10'($urandom_range(0, 255)), 2'b00};
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
